// File: rtl/multitrack_loop_controller.sv
// N-track looper front end: one async-RAM access per track each sample period,
// a record write for the armed track and reads for the rest, then a saturated mix.
module multitrack_loop_controller #(
  parameter int N_TRACKS    = 4,
  parameter int DATA_W      = 16,
  parameter int SLICE_W     = 20,
  parameter int SAMPLE_DIV  = 1563,
  parameter int WAIT_CYCLES = 6,
  localparam int TRK_W      = $clog2(N_TRACKS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rec_en,
  input  logic [TRK_W-1:0]    rec_track,
  input  logic [DATA_W-1:0]   rec_data,
  input  logic [N_TRACKS-1:0] play_mask,
  input  logic [SLICE_W-1:0]  loop_len,
  inout  wire  [DATA_W-1:0]   MemDB,
  output logic [22:0]         MemAdr,
  output logic                RamAdv,
  output logic                RamClk,
  output logic                RamCS,
  output logic                MemOE,
  output logic                MemWR,
  output logic                RamLB,
  output logic                RamUB,
  output logic [DATA_W-1:0]   mix_out,
  output logic                mix_valid,
  output logic [SLICE_W-1:0]  slice_pos,
  output logic                busy,
  output logic                overrun
);

  localparam int ACC_W = DATA_W + TRK_W + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int WC_W  = $clog2(WAIT_CYCLES + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic [6:0] CTL_IDLE = 7'b1111111;
  localparam logic [6:0] CTL_WR   = 7'b0001000;
  localparam logic [6:0] CTL_RD   = 7'b0000100;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RECOVER, MIX} state_t;

  state_t                    state, nxt;
  logic [DIV_W-1:0]          div_cnt;
  logic [TRK_W-1:0]          trk;
  logic [WC_W-1:0]           wcnt;
  logic                      rec_en_q;
  logic [TRK_W-1:0]          rec_track_q;
  logic [DATA_W-1:0]         rec_data_q;
  logic [N_TRACKS-1:0]       play_q;
  logic [DATA_W-1:0]         cap;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         mix_sat;
  logic [DATA_W-1:0]         add_word;
  logic [SLICE_W-1:0]        eff_last;
  logic [6:0]                ctl;
  logic                      db_oe;
  logic                      tick, is_wr, last_acc, last_trk;

  assign tick     = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign is_wr    = rec_en_q && (trk == rec_track_q);
  assign last_acc = (wcnt == WC_W'(WAIT_CYCLES - 1));
  assign last_trk = (trk == TRK_W'(N_TRACKS - 1));
  assign busy     = (state != IDLE);
  assign add_word = is_wr ? rec_data_q : cap;
  assign eff_last = (loop_len == '0) ? '1 : loop_len - SLICE_W'(1);

  // Address is live from track index and slice; both are zero in reset.
  assign MemAdr = 23'({trk, slice_pos});
  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctl;
  assign MemDB  = db_oe ? rec_data_q : 'z;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt   = state;
    ctl   = CTL_IDLE;
    db_oe = 1'b0;
    case (state)
      IDLE:    if (tick) nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS: begin
        ctl   = is_wr ? CTL_WR : CTL_RD;
        db_oe = is_wr;
        if (last_acc) nxt = RECOVER;
      end
      RECOVER: nxt = last_trk ? MIX : SETUP;
      MIX:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mix_sat = acc[DATA_W-1:0];
    if (acc > SAT_MAX)      mix_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc < SAT_MIN) mix_sat = {1'b1, {(DATA_W-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      trk         <= '0;
      wcnt        <= '0;
      rec_en_q    <= 1'b0;
      rec_track_q <= '0;
      rec_data_q  <= '0;
      play_q      <= '0;
      cap         <= '0;
      acc         <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      slice_pos   <= '0;
      overrun     <= 1'b0;
    end else begin
      div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
      mix_valid <= 1'b0;
      // A tick that lands on an in-flight period is dropped, only flagged.
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          rec_en_q    <= rec_en;
          rec_track_q <= rec_track;
          rec_data_q  <= rec_data;
          play_q      <= play_mask;
          acc         <= '0;
          trk         <= '0;
        end
        SETUP:  wcnt <= '0;
        ACCESS: begin
          wcnt <= wcnt + WC_W'(1);
          if (last_acc && !is_wr) cap <= MemDB;
        end
        RECOVER: begin
          if (play_q[trk])
            acc <= acc + $signed({{(ACC_W-DATA_W){add_word[DATA_W-1]}}, add_word});
          if (!last_trk) trk <= trk + TRK_W'(1);
        end
        MIX: begin
          mix_out   <= mix_sat;
          mix_valid <= 1'b1;
          slice_pos <= (slice_pos >= eff_last) ? '0 : slice_pos + SLICE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multitrack_loop_controller.sv
// Directed bench: RAM model returns a fixed word per track; mixes, access counts,
// write data/address, slice wrap, overrun and mid-access reset are checked.
module tb_multitrack_loop_controller;
  localparam logic [6:0] CTL_IDLE = 7'b1111111;
  localparam logic [6:0] CTL_WR   = 7'b0001000;
  localparam logic [6:0] CTL_RD   = 7'b0000100;

  logic        clk = 1'b0;
  logic        rst, rst_b, rec_en;
  logic [1:0]  rec_track;
  logic [15:0] rec_data;
  logic [3:0]  play_mask;
  logic [19:0] loop_len;

  wire  [15:0] MemDB, db_b;
  wire  [6:0]  ctl, ctl_b;
  logic [22:0] MemAdr, adr_b;
  logic [15:0] mix_out, mix_out_b;
  logic [19:0] slice_pos, slice_b;
  logic        mix_valid, busy, overrun, mix_valid_b, busy_b, overrun_b;

  logic [15:0] ram [4];

  int vecs = 0, errs = 0;
  int rd_cyc = 0, wr_cyc = 0, mix_cnt = 0;
  logic [15:0] wr_data = '0;
  logic [22:0] wr_adr  = '0;

  always #5 clk = ~clk;

  multitrack_loop_controller dut (
    .clk(clk), .rst(rst), .rec_en(rec_en), .rec_track(rec_track), .rec_data(rec_data),
    .play_mask(play_mask), .loop_len(loop_len), .MemDB(MemDB), .MemAdr(MemAdr),
    .RamAdv(ctl[6]), .RamClk(ctl[5]), .RamCS(ctl[4]), .MemOE(ctl[3]), .MemWR(ctl[2]),
    .RamLB(ctl[1]), .RamUB(ctl[0]), .mix_out(mix_out), .mix_valid(mix_valid),
    .slice_pos(slice_pos), .busy(busy), .overrun(overrun));

  multitrack_loop_controller #(.SAMPLE_DIV(20)) dut_b (
    .clk(clk), .rst(rst_b), .rec_en(rec_en), .rec_track(rec_track), .rec_data(rec_data),
    .play_mask(play_mask), .loop_len(loop_len), .MemDB(db_b), .MemAdr(adr_b),
    .RamAdv(ctl_b[6]), .RamClk(ctl_b[5]), .RamCS(ctl_b[4]), .MemOE(ctl_b[3]), .MemWR(ctl_b[2]),
    .RamLB(ctl_b[1]), .RamUB(ctl_b[0]), .mix_out(mix_out_b), .mix_valid(mix_valid_b),
    .slice_pos(slice_b), .busy(busy_b), .overrun(overrun_b));

  // RAM model: one word per track, driven while chip-selected with output enabled.
  assign MemDB = (ctl[4] == 1'b0 && ctl[3] == 1'b0) ? ram[MemAdr[21:20]] : 'z;

  always @(negedge clk) begin
    if (ctl == CTL_RD) rd_cyc <= rd_cyc + 1;
    if (ctl == CTL_WR) begin
      wr_cyc  <= wr_cyc + 1;
      wr_data <= MemDB;
      wr_adr  <= MemAdr;
    end
    if (mix_valid) mix_cnt <= mix_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_mix(input string tag);
    bit found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk); #1;
      if (mix_valid) found = 1;
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic set_ram(input int a, input int b, input int c, input int d);
    ram[0] = 16'(a); ram[1] = 16'(b); ram[2] = 16'(c); ram[3] = 16'(d);
  endtask

  initial begin
    int rb, wb, mb;
    int exp_slice [5] = '{1, 2, 0, 1, 2};
    bit found;
    rst = 1; rst_b = 1; rec_en = 0; rec_track = 0; rec_data = 0;
    play_mask = 4'hF; loop_len = 0;
    set_ram(100, 200, -50, 7);

    // reset state
    cycles(3);
    chk("rst_ctl", ctl, CTL_IDLE);
    chk("rst_adr", MemAdr, 0);
    chk("rst_mix", mix_out, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_slice", slice_pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    // plain playback of four tracks
    rst = 0;
    rb = rd_cyc; wb = wr_cyc; mb = mix_cnt;
    wait_mix("basic");
    chk("basic_mix", $signed(mix_out), 257);
    chk("basic_rd_cycles", rd_cyc - rb, 24);
    chk("basic_wr_cycles", wr_cyc - wb, 0);
    chk("basic_slice", slice_pos, 1);
    chk("basic_busy_low", busy, 0);
    cycles(3);
    chk("basic_pulses", mix_cnt - mb, 1);
    chk("basic_pulse_end", mix_valid, 0);

    // record track 2 with input monitoring; mid-period input changes ignored
    rec_en = 1; rec_track = 2; rec_data = 16'h1234;
    rb = rd_cyc; wb = wr_cyc;
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk); #1;
      if (busy) found = 1;
    end
    chk("rec_start", found, 1);
    rec_en = 0; rec_data = 16'h5555;
    wait_mix("rec");
    chk("rec_mix", $signed(mix_out), 100 + 200 + 16'h1234 + 7);
    chk("rec_wr_cycles", wr_cyc - wb, 6);
    chk("rec_rd_cycles", rd_cyc - rb, 18);
    chk("rec_wr_data", wr_data, 16'h1234);
    chk("rec_wr_adr", wr_adr, (2 << 20) | 1);
    chk("rec_slice", slice_pos, 2);

    // saturation both ways, then a partial play mask
    set_ram(32767, 32767, 0, 0);
    wait_mix("sat_hi");
    chk("sat_hi_mix", $signed(mix_out), 32767);
    set_ram(-32768, -1, 0, 0);
    wait_mix("sat_lo");
    chk("sat_lo_mix", $signed(mix_out), -32768);
    set_ram(100, 200, -50, 7);
    play_mask = 4'b0101;
    wait_mix("mask");
    chk("mask_mix", $signed(mix_out), 50);
    play_mask = 4'hF;

    // loop length 3 wrap, then shrink below current slice
    rst = 1;
    cycles(2);
    chk("rst2_slice", slice_pos, 0);
    rst = 0; loop_len = 3;
    for (int p = 0; p < 5; p++) begin
      wait_mix("loop");
      chk($sformatf("loop_slice%0d", p), slice_pos, exp_slice[p]);
    end
    loop_len = 1;
    wait_mix("shrink");
    chk("shrink_slice", slice_pos, 0);
    wait_mix("len1");
    chk("len1_slice", slice_pos, 0);

    // overrun with a too-short sample period, then reset mid-access
    rst_b = 0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk); #1;
      if (overrun_b) found = 1;
    end
    chk("ovr_set", overrun_b, 1);
    cycles(100);
    chk("ovr_sticky", overrun_b, 1);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk); #1;
      if (ctl_b == CTL_RD) found = 1;
    end
    chk("ovr_access_seen", found, 1);
    rst_b = 1;
    cycles(1);
    chk("midrst_ctl", ctl_b, CTL_IDLE);
    chk("midrst_busy", busy_b, 0);
    chk("midrst_overrun", overrun_b, 0);
    chk("midrst_adr", adr_b, 0);
    chk("main_no_overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
